// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared state encodings and transaction type constants
package atm_pkg;

  localparam int ST_W = 6;

  localparam logic [ST_W-1:0] ST_IDLE    = 6'b000001;
  localparam logic [ST_W-1:0] ST_PIN     = 6'b000010;
  localparam logic [ST_W-1:0] ST_CHECK   = 6'b000100;
  localparam logic [ST_W-1:0] ST_TRANS   = 6'b001000;
  localparam logic [ST_W-1:0] ST_DONE    = 6'b010000;
  localparam logic [ST_W-1:0] ST_BLOQUEO = 6'b100000;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

endpackage

// File: rtl/atm_pin_capture.sv
// rtl/atm_pin_capture.sv - PIN digit shift register, digit counter and compare
module atm_pin_capture #(
  parameter int PIN_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_shift,
  input  logic [3:0]              i_digito,
  input  logic [4*PIN_DIGITS-1:0] i_pin_ref,
  output logic                    o_last,
  output logic                    o_match
);

  logic [4*PIN_DIGITS-1:0] r_pin;
  logic [3:0]              r_count;
  logic [4*PIN_DIGITS-1:0] w_pin_next;

  generate
    if (PIN_DIGITS == 1) begin : g_single
      assign w_pin_next = i_digito;
    end else begin : g_multi
      assign w_pin_next = {r_pin[4*PIN_DIGITS-5:0], i_digito};
    end
  endgenerate

  // Clearing only touches the counter so the captured PIN stays valid for compare.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pin   <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_shift) begin
      r_pin   <= w_pin_next;
      r_count <= r_count + 4'd1;
    end
  end

  assign o_last  = (r_count == 4'(PIN_DIGITS - 1));
  assign o_match = (r_pin == i_pin_ref);

endmodule

// File: rtl/atm_transaction_ctrl.sv
// rtl/atm_transaction_ctrl.sv - card/PIN/transaction sequencer with retry lockout
// Optional inactivity timeout in PIN/TRANS enabled by ATM_TIMEOUT_EN.
module atm_transaction_ctrl
  import atm_pkg::*;
#(
  parameter int                   PIN_DIGITS     = 4,
  parameter int                   MAX_INTENTOS   = 3,
  parameter int                   MONTO_W        = 32,
  parameter int                   BALANCE_W      = 64,
  parameter logic [BALANCE_W-1:0] BALANCE_INIT   = '0,
  parameter int                   TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tarjeta_recibida,
  input  logic [4*PIN_DIGITS-1:0] pin_correcto,
  input  logic [3:0]              digito,
  input  logic                    digito_stb,
  input  logic                    tipo_trans,
  input  logic [MONTO_W-1:0]      monto,
  input  logic                    monto_stb,
  output logic [BALANCE_W-1:0]    balance,
  output logic                    balance_actualizado,
  output logic                    entregar_dinero,
  output logic                    fondos_insuficientes,
  output logic                    pin_incorrecto,
  output logic                    advertencia,
  output logic                    bloqueo,
  output logic                    fin
);

  logic [ST_W-1:0]      r_state;
  logic [BALANCE_W-1:0] r_balance;
  logic [3:0]           r_intentos;
  logic                 r_upd, r_ent, r_fondos, r_pin_inc, r_adv, r_bloq, r_fin;

  logic                 w_last, w_match, w_clear, w_shift, w_to_hit;
  logic [3:0]           w_int_next;
  logic [BALANCE_W-1:0] w_monto_ext;
  logic [BALANCE_W:0]   w_sum;

  assign w_clear     = (r_state == ST_IDLE) || (r_state == ST_CHECK);
  assign w_shift     = (r_state == ST_PIN) && digito_stb;
  assign w_int_next  = r_intentos + 4'd1;
  assign w_monto_ext = BALANCE_W'(monto);
  assign w_sum       = {1'b0, r_balance} + {1'b0, w_monto_ext};

  atm_pin_capture #(.PIN_DIGITS(PIN_DIGITS)) u_pin (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_clear),
    .i_shift  (w_shift),
    .i_digito (digito),
    .i_pin_ref(pin_correcto),
    .o_last   (w_last),
    .o_match  (w_match)
  );

`ifdef ATM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to;

  assign w_to_hit = ((r_state == ST_PIN) || (r_state == ST_TRANS)) &&
                    (r_to == TO_W'(TIMEOUT_CYCLES - 1));

  // Held at zero outside PIN/TRANS, so every entry into those states starts fresh.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_to <= '0;
    end else if (!((r_state == ST_PIN) || (r_state == ST_TRANS)) || w_to_hit ||
                 ((r_state == ST_PIN) && digito_stb) ||
                 ((r_state == ST_TRANS) && monto_stb)) begin
      r_to <= '0;
    end else begin
      r_to <= r_to + 1'b1;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_balance  <= BALANCE_INIT;
      r_intentos <= '0;
      r_upd      <= 1'b0;
      r_ent      <= 1'b0;
      r_fondos   <= 1'b0;
      r_pin_inc  <= 1'b0;
      r_adv      <= 1'b0;
      r_bloq     <= 1'b0;
      r_fin      <= 1'b0;
    end else begin
      r_upd     <= 1'b0;
      r_ent     <= 1'b0;
      r_fondos  <= 1'b0;
      r_pin_inc <= 1'b0;
      r_fin     <= 1'b0;
      case (r_state)
        ST_IDLE: if (tarjeta_recibida) r_state <= ST_PIN;
        ST_PIN: begin
          if (digito_stb && w_last) begin
            r_state <= ST_CHECK;
          end else if (w_to_hit) begin
            r_state <= ST_IDLE;
            r_fin   <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (w_match) begin
            r_state    <= ST_TRANS;
            r_intentos <= '0;
            r_adv      <= 1'b0;
          end else begin
            r_intentos <= w_int_next;
            r_pin_inc  <= 1'b1;
            if (w_int_next == 4'(MAX_INTENTOS)) begin
              r_state <= ST_BLOQUEO;
              r_bloq  <= 1'b1;
            end else begin
              if (w_int_next == 4'(MAX_INTENTOS - 1)) r_adv <= 1'b1;
              r_state <= ST_PIN;
            end
          end
        end
        ST_TRANS: begin
          if (monto_stb) begin
            r_state <= ST_DONE;
            if (tipo_trans == TIPO_DEPOSITO) begin
              r_balance <= w_sum[BALANCE_W] ? '1 : w_sum[BALANCE_W-1:0];
              r_upd     <= 1'b1;
            end else if (w_monto_ext <= r_balance) begin
              r_balance <= r_balance - w_monto_ext;
              r_upd     <= 1'b1;
              r_ent     <= 1'b1;
            end else begin
              r_fondos  <= 1'b1;
            end
          end else if (w_to_hit) begin
            r_state <= ST_IDLE;
            r_fin   <= 1'b1;
          end
        end
        ST_DONE: begin
          r_fin   <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_BLOQUEO: r_state <= ST_BLOQUEO;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign balance              = r_balance;
  assign balance_actualizado  = r_upd;
  assign entregar_dinero      = r_ent;
  assign fondos_insuficientes = r_fondos;
  assign pin_incorrecto       = r_pin_inc;
  assign advertencia          = r_adv;
  assign bloqueo              = r_bloq;
  assign fin                  = r_fin;

endmodule

// File: tb/tb_atm_transaction_ctrl.sv
// tb/tb_atm_transaction_ctrl.sv - directed table-driven bench for atm_transaction_ctrl
module tb_atm_transaction_ctrl;

  localparam int BW = 33;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tarjeta_recibida = 1'b0;
  logic [15:0]   pin_correcto = 16'h1234;
  logic [3:0]    digito = 4'd0;
  logic          digito_stb = 1'b0;
  logic          tipo_trans = 1'b0;
  logic [31:0]   monto = 32'd0;
  logic          monto_stb = 1'b0;
  logic [BW-1:0] balance;
  logic          balance_actualizado, entregar_dinero, fondos_insuficientes;
  logic          pin_incorrecto, advertencia, bloqueo, fin;

  int n_tests = 0;
  int n_fail  = 0;
  logic seen_fin, seen_upd, seen_ent, seen_pin;

  atm_transaction_ctrl #(
    .PIN_DIGITS(4), .MAX_INTENTOS(3), .MONTO_W(32), .BALANCE_W(BW),
    .BALANCE_INIT('0), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .tarjeta_recibida(tarjeta_recibida),
    .pin_correcto(pin_correcto), .digito(digito), .digito_stb(digito_stb),
    .tipo_trans(tipo_trans), .monto(monto), .monto_stb(monto_stb),
    .balance(balance), .balance_actualizado(balance_actualizado),
    .entregar_dinero(entregar_dinero), .fondos_insuficientes(fondos_insuficientes),
    .pin_incorrecto(pin_incorrecto), .advertencia(advertencia),
    .bloqueo(bloqueo), .fin(fin)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tipo;
    logic [31:0] monto;
    logic [63:0] bal;
    logic        upd;
    logic        ent;
    logic        fi;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    #1;
    seen_fin = seen_fin | fin;
    seen_upd = seen_upd | balance_actualizado;
    seen_ent = seen_ent | entregar_dinero;
    seen_pin = seen_pin | pin_incorrecto;
  endtask

  task automatic clear_seen();
    seen_fin = 0; seen_upd = 0; seen_ent = 0; seen_pin = 0;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic card();
    tarjeta_recibida = 1'b1;
    tick();
    tarjeta_recibida = 1'b0;
  endtask

  // Leaves the DUT in CHECK; the caller ticks once more to see the verdict.
  task automatic enter_pin(input logic [15:0] p);
    for (int i = 0; i < 4; i++) begin
      digito     = p[15-4*i -: 4];
      digito_stb = 1'b1;
      tick();
    end
    digito_stb = 1'b0;
  endtask

  task automatic trans(input logic t, input logic [31:0] m);
    tipo_trans = t;
    monto      = m;
    monto_stb  = 1'b1;
    tick();
    monto_stb  = 1'b0;
  endtask

  logic [63:0] prev_bal;
  int          cnt;

  initial begin
    vecs[0]  = '{1'b0, 32'd500,        64'd500,        1, 0, 0};
    vecs[1]  = '{1'b1, 32'd200,        64'd300,        1, 1, 0};
    vecs[2]  = '{1'b1, 32'd400,        64'd300,        0, 0, 1};
    vecs[3]  = '{1'b1, 32'd300,        64'd0,          1, 1, 0};
    vecs[4]  = '{1'b0, 32'd0,          64'd0,          1, 0, 0};
    vecs[5]  = '{1'b1, 32'd0,          64'd0,          1, 1, 0};
    vecs[6]  = '{1'b1, 32'd1,          64'd0,          0, 0, 1};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  64'd4294967295, 1, 0, 0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  64'd8589934590, 1, 0, 0};
    vecs[9]  = '{1'b0, 32'd5,          64'd8589934591, 1, 0, 0};
    vecs[10] = '{1'b1, 32'd1,          64'd8589934590, 1, 1, 0};

    clear_seen();
    tick(); tick();
    reset = 1'b1;
    check("reset_balance", balance, 0);
    check("reset_pulses", {balance_actualizado, entregar_dinero, fondos_insuficientes,
                           pin_incorrecto, fin}, 0);
    check("reset_levels", {advertencia, bloqueo}, 0);

    prev_bal = 0;
    for (int v = 0; v < 11; v++) begin
      // Strobes in IDLE must be ignored.
      digito = 4'd9; digito_stb = 1'b1; monto = 32'd1234; tipo_trans = 1'b0; monto_stb = 1'b1;
      tick();
      digito_stb = 1'b0; monto_stb = 1'b0;
      check($sformatf("v%0d_idle_ignore", v), balance, prev_bal);
      card();
      enter_pin(16'h1234);
      tick();
      check($sformatf("v%0d_pin_ok", v), pin_incorrecto, 0);
      trans(vecs[v].tipo, vecs[v].monto);
      check($sformatf("v%0d_balance", v), balance, vecs[v].bal);
      check($sformatf("v%0d_flags", v),
            {balance_actualizado, entregar_dinero, fondos_insuficientes},
            {vecs[v].upd, vecs[v].ent, vecs[v].fi});
      check($sformatf("v%0d_fin_early", v), fin, 0);
      tick();
      check($sformatf("v%0d_fin", v), {fin, balance_actualizado}, 2'b10);
      tick();
      check($sformatf("v%0d_fin_once", v), fin, 0);
      prev_bal = vecs[v].bal;
    end

    // Two wrong PINs then the correct one.
    card();
    enter_pin(16'h1111); tick();
    check("w1_pin_inc", {pin_incorrecto, advertencia, bloqueo}, 3'b100);
    enter_pin(16'h2222); tick();
    check("w2_adv", {pin_incorrecto, advertencia, bloqueo}, 3'b110);
    enter_pin(16'h1234); tick();
    check("ok_adv_drop", {pin_incorrecto, advertencia}, 2'b00);
    trans(1'b0, 32'd0);
    check("ok_trans_upd", balance_actualizado, 1);
    tick(); tick();

    // Next session starts a fresh attempt count.
    card();
    enter_pin(16'h4321); tick();
    check("s2_w1_no_adv", {pin_incorrecto, advertencia}, 2'b10);
    enter_pin(16'h1234); tick();
    trans(1'b1, 32'd0);
    check("s2_ent", entregar_dinero, 1);
    tick(); tick();

    // Lockout after three misses.
    card();
    enter_pin(16'h0000); tick();
    check("l1", {pin_incorrecto, advertencia, bloqueo}, 3'b100);
    enter_pin(16'h0001); tick();
    check("l2", {pin_incorrecto, advertencia, bloqueo}, 3'b110);
    enter_pin(16'h0002); tick();
    check("l3_bloqueo", {pin_incorrecto, bloqueo}, 2'b11);
    tick();
    check("l3_pulse_once", pin_incorrecto, 0);
    clear_seen();
    card();
    enter_pin(16'h1234); tick();
    trans(1'b0, 32'd9); tick(); tick();
    check("lock_ignore_bal", balance, 64'd8589934590);
    check("lock_no_pulses", {seen_fin, seen_upd, seen_ent, seen_pin}, 0);
    check("lock_sticky", bloqueo, 1);

    reset = 1'b0; tick(); reset = 1'b1;
    check("rst2_state", {bloqueo, advertencia}, 0);
    check("rst2_balance", balance, 0);

    // Reset arriving together with monto_stb in TRANS.
    card();
    enter_pin(16'h1234); tick();
    tipo_trans = 1'b0; monto = 32'd77; monto_stb = 1'b1; reset = 1'b0;
    tick();
    monto_stb = 1'b0; reset = 1'b1;
    clear_seen();
    for (int i = 0; i < 4; i++) tick();
    check("midrst_balance", balance, 0);
    check("midrst_no_fin", {seen_fin, seen_upd}, 0);

    card();
    enter_pin(16'h1234); tick();
    trans(1'b0, 32'd7);
    check("post_rst_dep", balance, 7);
    tick(); tick();

`ifdef ATM_TIMEOUT_EN
    card();
    cnt = 0;
    while (!fin && cnt < 40) begin
      tick();
      cnt++;
    end
    check("timeout_cycles", cnt, 16);
    check("timeout_balance", balance, 7);
    tick();
    check("timeout_fin_once", fin, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/atm_transaction_ctrl.md
# atm_transaction_ctrl

Parametrised ATM transaction controller; next generation of the card/PIN/transaction sequencer. Accepts a card, collects a multi-digit PIN one BCD digit at a time, enforces a bounded retry count with lockout, then executes one deposit or withdrawal against an internal balance register and signals completion. Sits between the keypad/card-reader front end and the cash dispenser / display logic.

## Interface
- PIN_DIGITS, 4: number of 4-bit digits per PIN (1..8)
- MAX_INTENTOS, 3: wrong-PIN attempts before lockout (2..15)
- MONTO_W, 32: width of transaction amount
- BALANCE_W, 64: width of balance register (≥ MONTO_W)
- BALANCE_INIT, 0: balance value loaded at reset
- TIMEOUT_CYCLES, 1024: inactivity limit; used only with ATM_TIMEOUT_EN
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low
- tarjeta_recibida  in  1  card inserted strobe; sampled in IDLE only
- pin_correcto  in  4*PIN_DIGITS  stored PIN, first digit in MS nibble; static during a session
- digito  in  4  keypad digit
- digito_stb  in  1  digito valid this cycle; sampled in PIN only
- tipo_trans  in  1  0 = deposit, 1 = withdrawal; sampled with monto_stb
- monto  in  MONTO_W  amount, unsigned
- monto_stb  in  1  monto/tipo_trans valid; sampled in TRANS only
- balance  out  BALANCE_W  current balance
- balance_actualizado  out  1  one-cycle pulse, balance changed
- entregar_dinero  out  1  one-cycle pulse, dispense monto
- fondos_insuficientes  out  1  one-cycle pulse, withdrawal rejected
- pin_incorrecto  out  1  one-cycle pulse, PIN mismatch
- advertencia  out  1  level, one attempt remaining
- bloqueo  out  1  level, card locked; sticky until reset
- fin  out  1  one-cycle pulse, session finished

## Operation
- One-hot states: IDLE, PIN, CHECK, TRANS, DONE, BLOQUEO.
- IDLE: tarjeta_recibida=1 -> PIN; digit count cleared.
- PIN: each digito_stb shifts digito into PIN register (left shift, new digit LS nibble), count+1; on strobe making count==PIN_DIGITS -> CHECK.
- CHECK (one cycle): compare captured PIN with pin_correcto. Match -> TRANS, intentos:=0, advertencia:=0. Mismatch -> intentos+1, pin_incorrecto pulse; new intentos==MAX_INTENTOS -> BLOQUEO, bloqueo:=1; new intentos==MAX_INTENTOS-1 -> advertencia:=1; otherwise -> PIN with count cleared.
- TRANS: on monto_stb, deposit: balance := balance + zero-extended monto, saturating at 2^BALANCE_W-1; balance_actualizado pulses (also if saturated). Withdrawal with monto ≤ balance: balance -= monto, balance_actualizado and entregar_dinero pulse. Withdrawal with monto > balance: balance unchanged, fondos_insuficientes pulses. All cases -> DONE.
- DONE (one cycle): fin pulses, -> IDLE.
- BLOQUEO: all inputs ignored; only reset exits. intentos survives between sessions; cleared only by correct PIN or reset.
- Strobes outside their sampling state ignored; monto=0 is a valid transaction.
- Reset values: state IDLE, balance=BALANCE_INIT, all pulses and levels 0, intentos=0, digit count 0. Reset mid-session aborts with no balance change and no fin.

## Timing
- All outputs registered; no combinational input-to-output path.
- Last digito_stb at edge E0 -> CHECK after E0; pin_incorrecto/bloqueo/advertencia update and next state take effect after E1.
- monto_stb at edge E0 -> balance and result pulses valid after E0; fin high after E1 for one cycle; IDLE after E1, new card accepted at E2.
- Minimum session: card + PIN_DIGITS strobes + 1 CHECK + monto_stb + 1 DONE.

## Configuration
- ATM_TIMEOUT_EN defined: counter reset on every accepted strobe and on state entry; TIMEOUT_CYCLES consecutive idle cycles in PIN or TRANS -> IDLE, fin pulses, balance unchanged, intentos kept. Never active in IDLE, CHECK, DONE, BLOQUEO.
- Undefined: no counter; PIN and TRANS wait indefinitely.

## Structure
- Package atm_pkg: one-hot state localparams and width, TIPO_DEPOSITO/TIPO_RETIRO constants.
- Sub-module atm_pin_capture: digit shift register, digit counter, full flag, equality compare.

## Test plan
- Reset, card, PIN 1-2-3-4 matching, deposit 500 -> balance 500, balance_actualizado 1 cycle, fin one cycle later.
- Balance 500, withdraw 200 -> balance 300, entregar_dinero pulse; then withdraw 400 -> fondos_insuficientes, balance 300, no entregar_dinero.
- Three wrong PINs (MAX_INTENTOS=3) -> pin_incorrecto ×3, advertencia after 2nd, bloqueo after 3rd; later card and strobes ignored until reset.
- Two wrong then correct PIN -> advertencia drops, transaction proceeds; next session again allows 3 attempts.
- Deposit overflowing BALANCE_W -> balance saturates at all-ones; reset mid-TRANS -> balance=BALANCE_INIT, fin never pulses.
- With ATM_TIMEOUT_EN, TIMEOUT_CYCLES=16: card then no digits 16 cycles -> fin pulse, IDLE, balance unchanged.
